// File: rtl/pe_pkg.sv
// Shared constants and FSM encoding for the systolic MAC processing element.
package pe_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_e;

endpackage

// File: rtl/systolic_mac_pe_mult.sv
// 16x16 unsigned multiplier used between the pass-through and product stages.
module WT_Multiplier16x16
  import pe_pkg::*;
(
  output logic [PROD_W-1:0] product,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b
);

  assign product = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic-array MAC element: forwards operands east/south, accumulates K_LEN valid
// products and presents each completed dot product through a ready/valid result port.
module systolic_mac_pe
  import pe_pkg::*;
#(
  parameter int K_LEN = 16,
  parameter int ACC_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              valid_in,
  input  logic              clr,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              ovr_err
);

  localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);

  if (K_LEN < 1 || K_LEN > 256) begin : g_bad_k_len
    $error("systolic_mac_pe: K_LEN must be in 1..256");
  end
  if (ACC_W < PROD_W + $clog2(K_LEN)) begin : g_bad_acc_w
    $error("systolic_mac_pe: ACC_W too narrow for K_LEN full-scale products");
  end

  logic [DATA_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic              valid_out_q, valid_out_d;
  logic [PROD_W-1:0] prod_q, prod_d, mult_product;
  logic              prod_v_q, prod_v_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_base, acc_sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  pe_state_e         state_q, state_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              ovr_err_q, ovr_err_d;

  WT_Multiplier16x16 u_mult (
    .product (mult_product),
    .a       (a_out_q),
    .b       (b_out_q)
  );

  // IDLE always means an empty accumulator, so the first product starts from zero.
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;
  assign acc_sum  = acc_base + ACC_W'(prod_q);

  always_comb begin
    a_out_d        = a_in;
    b_out_d        = b_in;
    valid_out_d    = valid_in;
    prod_d         = mult_product;
    prod_v_d       = valid_out_q && !clr;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    state_d        = state_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    ovr_err_d      = ovr_err_q;

    if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end

    // clr drops the stage-3 product and any partial sum; the result port is untouched.
    if (clr) begin
      acc_d     = '0;
      cnt_d     = '0;
      state_d   = IDLE;
      ovr_err_d = 1'b0;
    end else if (prod_v_q) begin
      if (cnt_q == CNT_LAST) begin
        result_d       = acc_sum;
        result_valid_d = 1'b1;
        if (result_valid_q && !result_ready) begin
          ovr_err_d = 1'b1;
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        acc_d   = acc_sum;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out_q        <= '0;
      b_out_q        <= '0;
      valid_out_q    <= 1'b0;
      prod_q         <= '0;
      prod_v_q       <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      state_q        <= IDLE;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovr_err_q      <= 1'b0;
    end else begin
      a_out_q        <= a_out_d;
      b_out_q        <= b_out_d;
      valid_out_q    <= valid_out_d;
      prod_q         <= prod_d;
      prod_v_q       <= prod_v_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ovr_err_q      <= ovr_err_d;
    end
  end

  assign a_out        = a_out_q;
  assign b_out        = b_out_q;
  assign valid_out    = valid_out_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign ovr_err      = ovr_err_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Drives four PEs (K_LEN = 1, 2, 4, 16) with shared stimulus and checks them against
// a transaction-level model built from the input history of each clock edge.
module tb_systolic_mac_pe;

  localparam int N = 4;
  localparam int HIST = 8192;

  function automatic int k_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 16;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        valid_in = 1'b0;
  logic        clr = 1'b0;
  logic        result_ready = 1'b0;

  logic [15:0] a_out_w [N];
  logic [15:0] b_out_w [N];
  logic        valid_out_w [N];
  logic [35:0] result_w [N];
  logic        rv_w [N];
  logic        ovr_w [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    systolic_mac_pe #(.K_LEN(k_of(gi)), .ACC_W(36)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_in         (a_in),
      .b_in         (b_in),
      .valid_in     (valid_in),
      .clr          (clr),
      .a_out        (a_out_w[gi]),
      .b_out        (b_out_w[gi]),
      .valid_out    (valid_out_w[gi]),
      .result       (result_w[gi]),
      .result_valid (rv_w[gi]),
      .result_ready (result_ready),
      .ovr_err      (ovr_w[gi])
    );
  end

  // Input history per edge: a pair sampled at edge s is summed at edge s+2 unless
  // clr hits edge s+1 or s+2, or reset hits any of edges s..s+2.
  logic [15:0] ha [HIST];
  logic [15:0] hb [HIST];
  bit          hv [HIST];
  bit          hclr [HIST];
  bit          hrn [HIST];
  int          edge_n = 0;

  longint unsigned m_sum [N];
  int              m_cnt [N];
  longint unsigned m_res [N];
  bit              m_rv [N];
  bit              m_ovr [N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic v,
                      input logic c, input logic r, input logic rn);
    int  e;
    bit  ok;
    bit  was_rv;
    a_in = a; b_in = b; valid_in = v; clr = c; result_ready = r; rst_n = rn;
    @(posedge clk);
    e = edge_n;
    ha[e] = a; hb[e] = b; hv[e] = v; hclr[e] = c; hrn[e] = rn;
    ok = (e >= 2) && hv[e-2] && hrn[e-2] && hrn[e-1] && rn && !hclr[e-1] && !c;
    for (int i = 0; i < N; i++) begin
      if (!rn) begin
        m_sum[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_rv[i] = 0; m_ovr[i] = 0;
      end else begin
        was_rv = m_rv[i];
        if (was_rv && r) m_rv[i] = 0;
        if (c) begin
          m_sum[i] = 0; m_cnt[i] = 0; m_ovr[i] = 0;
        end else if (ok) begin
          m_sum[i] = m_sum[i] + 64'(ha[e-2]) * 64'(hb[e-2]);
          m_cnt[i]++;
          if (m_cnt[i] == k_of(i)) begin
            if (was_rv && !r) m_ovr[i] = 1;
            m_res[i] = m_sum[i];
            m_rv[i]  = 1;
            m_sum[i] = 0;
            m_cnt[i] = 0;
          end
        end
      end
    end
    edge_n++;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("a_out k=%0d edge=%0d", k_of(i), e), 64'(a_out_w[i]), rn ? 64'(a) : 64'd0);
      chk($sformatf("b_out k=%0d edge=%0d", k_of(i), e), 64'(b_out_w[i]), rn ? 64'(b) : 64'd0);
      chk($sformatf("valid_out k=%0d edge=%0d", k_of(i), e), 64'(valid_out_w[i]), 64'(rn & v));
      chk($sformatf("result k=%0d edge=%0d", k_of(i), e), 64'(result_w[i]), m_res[i]);
      chk($sformatf("result_valid k=%0d edge=%0d", k_of(i), e), 64'(rv_w[i]), 64'(m_rv[i]));
      chk($sformatf("ovr_err k=%0d edge=%0d", k_of(i), e), 64'(ovr_w[i]), 64'(m_ovr[i]));
    end
  endtask

  task automatic idle(input logic r);
    step(16'd0, 16'd0, 1'b0, 1'b0, r, 1'b1);
  endtask

  task automatic flush();
    repeat (3) idle(1'b1);
    step(16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
  endtask

  localparam longint unsigned EXP35 = 64'(65535 * 60) + 64'(1000 * 500) + 64'(1 * 1) + 64'(0 * 7);

  initial begin
    logic [15:0] ra, rb;

    // Reset state
    step(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(16'd7, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_result_k16", 64'(result_w[3]), 64'd0);
    chk("reset_valid_out_k1", 64'(valid_out_w[0]), 64'd0);
    idle(1'b0);

    // K=1 single pair: pass-through one edge later, result three edges after driving
    step(16'd1024, 16'd60, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("k1_a_out", 64'(a_out_w[0]), 64'd1024);
    chk("k1_valid_out", 64'(valid_out_w[0]), 64'd1);
    chk("k1_rv_edge1", 64'(rv_w[0]), 64'd0);
    idle(1'b0);
    chk("k1_rv_edge2", 64'(rv_w[0]), 64'd0);
    idle(1'b0);
    chk("k1_rv_edge3", 64'(rv_w[0]), 64'd1);
    chk("k1_result", 64'(result_w[0]), 64'd61440);
    flush();

    // K=4 with bubbles
    step(16'd65535, 16'd60, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    step(16'd1000, 16'd500, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    step(16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd0, 16'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b0);
    chk("k4_bubbles_result", 64'(result_w[2]), EXP35);
    chk("k4_bubbles_rv", 64'(rv_w[2]), 64'd1);
    chk("k4_bubbles_ovr", 64'(ovr_w[2]), 64'd0);
    flush();

    // K=16 full-scale operands
    repeat (16) step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b0);
    chk("k16_fullscale_result", 64'(result_w[3]), 64'd68717379600);
    chk("k16_fullscale_rv", 64'(rv_w[3]), 64'd1);
    flush();

    // K=2 overwrite while result_ready is held low, then clr and a ready pulse
    step(16'd300, 16'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd11, 16'd13, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd1000, 16'd1000, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd2, 16'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b0);
    chk("k2_overwrite_result", 64'(result_w[1]), 64'd1000006);
    chk("k2_overwrite_ovr", 64'(ovr_w[1]), 64'd1);
    step(16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("k2_clr_ovr", 64'(ovr_w[1]), 64'd0);
    chk("k2_clr_rv_kept", 64'(rv_w[1]), 64'd1);
    idle(1'b1);
    chk("k2_ready_drops_rv", 64'(rv_w[1]), 64'd0);
    flush();

    // K=2 clr on the completion edge, then a fresh sum
    step(16'd5, 16'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd7, 16'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    step(16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("k2_clr_completion_result", 64'(result_w[1]), 64'd1000006);
    chk("k2_clr_completion_rv", 64'(rv_w[1]), 64'd0);
    step(16'd9, 16'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd11, 16'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b0);
    chk("k2_fresh_result", 64'(result_w[1]), 64'd222);
    chk("k2_fresh_rv", 64'(rv_w[1]), 64'd1);
    flush();

    // K=4 reset after two pairs
    step(16'd100, 16'd200, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd300, 16'd400, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("k4_reset_result", 64'(result_w[2]), 64'd0);
    chk("k4_reset_a_out", 64'(a_out_w[2]), 64'd0);
    step(16'd2, 16'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd4, 16'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd6, 16'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    step(16'd8, 16'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b0);
    chk("k4_after_reset_result", 64'(result_w[2]), 64'd140);
    chk("k4_after_reset_rv", 64'(rv_w[2]), 64'd1);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      case ($urandom % 4)
        0:       ra = 16'd0;
        1:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom % 4)
        0:       rb = 16'd0;
        1:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      step(ra, rb, ($urandom % 4) != 0, ($urandom % 23) == 0,
           ($urandom % 3) == 0, ($urandom % 61) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
